// File: rtl/mdom_wvb_rdout_ctrl.sv
// Waveform-buffer readout controller: pops one header bundle per event, streams it as
// 7 header words followed by the wrapped waveform samples through a small skid FIFO.

module mdom_wvb_rdout_ctrl_chk #(
    parameter int P_OCC_W = 3
) (
    input logic               clk,
    input logic               rst,
    input logic               push_i,
    input logic               pop_i,
    input logic               full_i
);

    // The credit scheme must keep the skid FIFO from ever being written while full.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && full_i && !pop_i))
                else $error("mdom_wvb_rdout_ctrl: skid FIFO overflow");
        end
    end

endmodule

module mdom_wvb_rdout_ctrl #(
    parameter int P_ADDR_W     = 11,
    parameter int P_FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hdr_empty,
    input  logic [102:0]        hdr_bundle,
    output logic                hdr_rd_en,
    output logic [P_ADDR_W-1:0] wvb_rd_addr,
    output logic                wvb_rd_en,
    input  logic [15:0]         wvb_data,
    output logic [15:0]         dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                wvb_rd_done,
    output logic                busy
);

    localparam int PTR_W = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(P_FIFO_DEPTH + 1) + 1;
    localparam int CNT_W = P_ADDR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(P_FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_WV    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [102:0]        bundle_q, bundle_d;
    logic [2:0]          hdr_idx_q, hdr_idx_d;
    logic [P_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic                armed_q;

    logic [16:0]         mem_q [P_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;

    logic                pop_s;
    logic                push_s;
    logic [16:0]         push_data_s;
    logic                rd_en_s;
    logic                hdr_rd_en_s;
    logic                done_s;
    logic [16:0]         head_s;
    logic [111:0]        padded_s;
    logic [15:0]         hdr_word_s;
    logic [P_ADDR_W-1:0] span_s;
    logic [OCC_W-1:0]    slots_used_s;
    logic [OCC_W-1:0]    slots_free_s;
    logic                credit1_s;
    logic                credit2_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(P_FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign head_s       = mem_q[rd_ptr_q];
    assign dout_valid   = (occ_q != {OCC_W{1'b0}});
    assign dout         = dout_valid ? head_s[15:0] : 16'h0000;
    assign dout_last    = dout_valid ? head_s[16] : 1'b0;
    assign pop_s        = dout_valid && dout_ready;
    assign padded_s     = {9'b0_0000_0000, bundle_q};
    assign hdr_word_s   = padded_s[{hdr_idx_q, 4'b0000} +: 16];
    assign span_s       = hdr_bundle[60 +: P_ADDR_W] - hdr_bundle[49 +: P_ADDR_W];

    // Slots held = stored words + read returning next cycle; a pop this cycle frees one.
    assign slots_used_s = occ_q + {{(OCC_W-1){1'b0}}, inflight_q};
    assign slots_free_s = DEPTH_C + {{(OCC_W-1){1'b0}}, pop_s};
    assign credit1_s    = (slots_used_s < slots_free_s);
    assign credit2_s    = ((slots_used_s + OCC_W'(2)) <= slots_free_s);

    assign hdr_rd_en    = hdr_rd_en_s;
    assign wvb_rd_en    = rd_en_s;
    assign wvb_rd_addr  = rd_addr_q;
    assign wvb_rd_done  = done_s;
    assign busy         = (state_q != S_IDLE) || dout_valid;

    // Event sequencing, read issue and FIFO push selection.
    always_comb begin
        state_d         = state_q;
        bundle_d        = bundle_q;
        hdr_idx_d       = hdr_idx_q;
        rd_addr_d       = rd_addr_q;
        cnt_d           = cnt_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        hdr_rd_en_s     = 1'b0;
        rd_en_s         = 1'b0;
        push_s          = 1'b0;
        push_data_s     = 17'h0_0000;
        done_s          = 1'b0;

        if (inflight_q) begin
            push_s      = 1'b1;
            push_data_s = {inflight_last_q, wvb_data};
        end else begin
            push_s      = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && !hdr_empty && !rst) begin
                    hdr_rd_en_s = 1'b1;
                    bundle_d    = hdr_bundle;
                    rd_addr_d   = hdr_bundle[49 +: P_ADDR_W];
                    cnt_d       = {1'b0, span_s} + CNT_W'(1);
                    hdr_idx_d   = 3'd0;
                    state_d     = S_HDR;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_HDR: begin
                // Overlap the first read with the last header word so samples follow with no bubble.
                if ((hdr_idx_q == 3'd6) && credit2_s) begin
                    push_s          = 1'b1;
                    push_data_s     = {1'b0, hdr_word_s};
                    rd_en_s         = 1'b1;
                    rd_addr_d       = rd_addr_q + P_ADDR_W'(1);
                    cnt_d           = cnt_q - CNT_W'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (cnt_q == CNT_W'(1));
                    state_d         = (cnt_q == CNT_W'(1)) ? S_DRAIN : S_WV;
                end else if (credit1_s) begin
                    push_s      = 1'b1;
                    push_data_s = {1'b0, hdr_word_s};
                    if (hdr_idx_q == 3'd6) begin
                        state_d   = S_WV;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end else begin
                    state_d     = S_HDR;
                end
            end
            S_WV: begin
                if (credit1_s) begin
                    rd_en_s         = 1'b1;
                    rd_addr_d       = rd_addr_q + P_ADDR_W'(1);
                    cnt_d           = cnt_q - CNT_W'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (cnt_q == CNT_W'(1));
                    state_d         = (cnt_q == CNT_W'(1)) ? S_DRAIN : S_WV;
                end else begin
                    state_d         = S_WV;
                end
            end
            S_DRAIN: begin
                if (pop_s && head_s[16]) begin
                    done_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skid FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers, with reset flushing the FIFO and discarding any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bundle_q        <= 103'd0;
            hdr_idx_q       <= 3'd0;
            rd_addr_q       <= {P_ADDR_W{1'b0}};
            cnt_q           <= {CNT_W{1'b0}};
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            armed_q         <= 1'b0;
            wr_ptr_q        <= {PTR_W{1'b0}};
            rd_ptr_q        <= {PTR_W{1'b0}};
            occ_q           <= {OCC_W{1'b0}};
            for (int i = 0; i < P_FIFO_DEPTH; i++) begin
                mem_q[i] <= 17'h0_0000;
            end
        end else begin
            state_q         <= state_d;
            bundle_q        <= bundle_d;
            hdr_idx_q       <= hdr_idx_d;
            rd_addr_q       <= rd_addr_d;
            cnt_q           <= cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            armed_q         <= 1'b1;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_s;
            end
        end
    end

    mdom_wvb_rdout_ctrl_chk #(
        .P_OCC_W (OCC_W)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_s),
        .pop_i  (pop_s),
        .full_i (occ_q == DEPTH_C)
    );

endmodule

// File: tb/tb_mdom_wvb_rdout_ctrl.sv
// Directed scoreboard bench for mdom_wvb_rdout_ctrl: header FIFO and waveform buffer models
// feed the DUT; expected words and read addresses are queued at enqueue time.

module tb_mdom_wvb_rdout_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hdr_empty = 1'b1;
    logic [102:0] hdr_bundle = '0;
    logic         hdr_rd_en;
    logic [10:0]  wvb_rd_addr;
    logic         wvb_rd_en;
    logic [15:0]  wvb_data = 16'h0000;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic         dout_last;
    logic         wvb_rd_done;
    logic         busy;

    always #5 clk = ~clk;

    mdom_wvb_rdout_ctrl #(.P_ADDR_W(11), .P_FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .hdr_empty   (hdr_empty),
        .hdr_bundle  (hdr_bundle),
        .hdr_rd_en   (hdr_rd_en),
        .wvb_rd_addr (wvb_rd_addr),
        .wvb_rd_en   (wvb_rd_en),
        .wvb_data    (wvb_data),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .wvb_rd_done (wvb_rd_done),
        .busy        (busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [102:0] hq [$];
    logic [16:0]  sb [$];
    logic [10:0]  aq [$];

    int cyc = 0, hdr_pops = 0, last_hdr_cyc = -1, done_cnt = 0, done_cyc = -100;
    int last_gap = -1, first_valid_cyc = -1, first_hs = -1, last_hs = -1, rd_seen = 0;
    logic        hdr_take = 1'b0, rd_en_smp = 1'b0, stall_prev = 1'b0, prev_last = 1'b0;
    logic [10:0] rd_addr_smp = '0;
    logic [15:0] prev_dout = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wv(input logic [10:0] a);
        return {5'b0_0000, a} + 16'h0100;
    endfunction

    function automatic logic [102:0] mk(input logic [10:0] s, input logic [10:0] e);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[59:49] = s;
        r[70:60] = e;
        return r[102:0];
    endfunction

    task automatic push_expect(input logic [102:0] b);
        logic [111:0] padded;
        logic [10:0]  s, e, d, a;
        int           n;
        padded = {9'b0_0000_0000, b};
        for (int k = 0; k < 7; k++) sb.push_back({1'b0, padded[16*k +: 16]});
        s = b[59:49];
        e = b[70:60];
        d = e - s;
        n = int'(d) + 1;
        a = s;
        for (int i = 0; i < n; i++) begin
            sb.push_back({(i == n - 1), wv(a)});
            aq.push_back(a);
            a = a + 11'd1;
        end
    endtask

    task automatic enqueue(input logic [10:0] s, input logic [10:0] e);
        logic [102:0] b;
        b = mk(s, e);
        hq.push_back(b);
        push_expect(b);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        check({tag, "_done"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic settle(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        check({tag, "_addr_left"}, 32'(aq.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Header FIFO model (first-word-fall-through) and 1-cycle-latency waveform buffer.
    always @(posedge clk) begin
        if (rd_en_smp) wvb_data <= wv(rd_addr_smp);
        #1;
        if (hdr_take && hq.size() > 0) void'(hq.pop_front());
        hdr_empty  = (hq.size() == 0);
        hdr_bundle = hdr_empty ? '0 : hq[0];
    end

    // Output monitor: scoreboard compare, stall stability, read address and done checks.
    always @(negedge clk) begin
        logic [16:0] e;
        logic [10:0] ea;
        cyc++;
        if (rst) begin
            hdr_take   = 1'b0;
            rd_en_smp  = 1'b0;
            stall_prev = 1'b0;
            sb.delete();
            aq.delete();
        end else begin
            hdr_take    = hdr_rd_en;
            rd_en_smp   = wvb_rd_en;
            rd_addr_smp = wvb_rd_addr;
            if (hdr_rd_en) begin
                hdr_pops++;
                last_hdr_cyc = cyc;
                last_gap     = cyc - done_cyc;
            end
            if (wvb_rd_en) begin
                rd_seen++;
                if (aq.size() == 0) check("rd_unexpected", 32'(wvb_rd_addr), 32'hFFFF_FFFF);
                else begin
                    ea = aq.pop_front();
                    check("rd_addr", 32'(wvb_rd_addr), 32'(ea));
                end
            end
            if (stall_prev) begin
                check("stall_valid", 32'(dout_valid), 32'd1);
                check("stall_dout", 32'(dout), 32'(prev_dout));
                check("stall_last", 32'(dout_last), 32'(prev_last));
            end
            if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (dout_valid && dout_ready) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (sb.size() == 0) check("dout_unexpected", 32'({dout_last, dout}), 32'hFFFF_FFFF);
                else begin
                    e = sb.pop_front();
                    check("dout", 32'({dout_last, dout}), 32'(e));
                    check("rd_done_at_last", 32'(wvb_rd_done), 32'(e[16]));
                end
            end else begin
                check("rd_done_idle", 32'(wvb_rd_done), 32'd0);
            end
            if (wvb_rd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
        end
    end

    initial begin
        logic [102:0] b;
        int p0, d0, r0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_hdr_rd_en", 32'(hdr_rd_en), 32'd0);
        check("rst_rd_en", 32'(wvb_rd_en), 32'd0);
        check("rst_rd_addr", 32'(wvb_rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Basic event 10..13, ready high
        p0 = hdr_pops; d0 = done_cnt;
        first_valid_cyc = -1; first_hs = -1;
        enqueue(11'd10, 11'd13);
        wait_done(d0 + 1, 200, "basic");
        check("basic_hdr_pops", 32'(hdr_pops - p0), 32'd1);
        check("basic_latency", 32'(first_valid_cyc - last_hdr_cyc), 32'd2);
        check("basic_span", 32'(last_hs - first_hs), 32'd10);
        settle("basic");

        // Address wrap 2046..1
        d0 = done_cnt; first_hs = -1;
        enqueue(11'd2046, 11'd1);
        wait_done(d0 + 1, 200, "wrap");
        check("wrap_span", 32'(last_hs - first_hs), 32'd10);
        settle("wrap");

        // Single sample
        d0 = done_cnt; first_hs = -1;
        enqueue(11'd500, 11'd500);
        wait_done(d0 + 1, 200, "single");
        check("single_span", 32'(last_hs - first_hs), 32'd7);
        settle("single");

        // Full buffer: 2048 samples
        d0 = done_cnt; first_hs = -1;
        enqueue(11'd501, 11'd500);
        wait_done(d0 + 1, 3000, "full");
        check("full_span", 32'(last_hs - first_hs), 32'd2054);
        settle("full");

        // Random backpressure over a 20-sample event
        d0 = done_cnt;
        enqueue(11'd100, 11'd119);
        for (int i = 0; i < 600 && done_cnt < d0 + 1; i++) begin
            @(posedge clk);
            #1 dout_ready = 1'($urandom_range(0, 1));
        end
        #1 dout_ready = 1'b1;
        wait_done(d0 + 1, 50, "random");
        settle("random");

        // Two preloaded bundles
        d0 = done_cnt;
        enqueue(11'd300, 11'd305);
        enqueue(11'd700, 11'd702);
        wait_done(d0 + 2, 300, "two");
        check("two_gap", 32'(last_gap), 32'd1);
        settle("two");

        // Reset during WV of a 50-sample event, next bundle already queued
        d0 = done_cnt; r0 = rd_seen;
        enqueue(11'd1000, 11'd1049);
        for (int i = 0; i < 200 && rd_seen < r0 + 10; i++) @(posedge clk);
        check("abort_in_wv", 32'(rd_seen >= r0 + 10), 32'd1);
        b = mk(11'd1500, 11'd1507);
        hq.push_back(b);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push_expect(b);
        @(negedge clk);
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_last", 32'(dout_last), 32'd0);
        check("abort_rd_en", 32'(wvb_rd_en), 32'd0);
        check("abort_rd_addr", 32'(wvb_rd_addr), 32'd0);
        check("abort_hdr_rd_en", 32'(hdr_rd_en), 32'd0);
        check("abort_done", 32'(wvb_rd_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        wait_done(d0 + 1, 300, "after_abort");
        settle("after_abort");
        check("after_abort_hdr_left", 32'(hq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
